// File: rtl/iter_divider_pkg.sv
// Shared encodings for the iterative divider: FSM states and the ready/start
// handshake values the ALU already uses.
package iter_divider_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring step: shift the work register left, trial-subtract the
// divisor from the upper half and set the quotient bit when it fits.
module div_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0]  work_i,
  input  logic [WIDTH-1:0]  divisor_i,
  output logic [2*WIDTH:0]  work_o
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   diff;

  assign shifted = work_i << 1;
  // The partial remainder is always < 2*divisor, so bit WIDTH of diff is the borrow.
  assign diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_i};

  always_comb begin
    work_o = shifted;
    if (!diff[WIDTH]) begin
      work_o[2*WIDTH:WIDTH] = diff;
      work_o[0]             = 1'b1;
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result_o = {remainder, quotient}
// with a one-cycle ready_o pulse, cancellable by annul_i while the division runs.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [2*WIDTH:0] work_q;
  logic [2*WIDTH:0] work_next;
  logic [WIDTH-1:0] divisor_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  // Sign handling only in signed mode; -2^(W-1) maps onto itself, which is the
  // correct unsigned magnitude.
  assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign a_mag = a_neg ? -opdata1_i : opdata1_i;
  assign b_mag = b_neg ? -opdata2_i : opdata2_i;

  assign rem = work_q[2*WIDTH-1:WIDTH];
  assign quo = work_q[WIDTH-1:0];

  div_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      ready_o <= DivResultNotReady;
      case (state_q)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q   <= DivOn;
              cnt_q     <= '0;
              work_q    <= {{(WIDTH+1){1'b0}}, a_mag};
              divisor_q <= b_mag;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            state_q   <= DivEnd;
            work_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            work_q <= work_next;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
              state_q <= DivEnd;
            end
          end
        end
        DivEnd: begin
          result_o <= {neg_rem_q ? -rem : rem, neg_quo_q ? -quo : quo};
          ready_o  <= DivResultReady;
          state_q  <= DivFree;
        end
        default: state_q <= DivFree;
      endcase
    end
  end

endmodule
